issue_queue: RTL and testbench

Dual-entry-per-cycle in-order issue queue between instruction decode and execute. Accepts up to two `task_t` tasks per cycle from decode (slot 0 older than slot 1), buffers them in a circular FIFO, and issues up to two per cycle in program order once a register scoreboard shows their sources and destination free. Issue outputs are registered and handshaked with the execute stage. Writeback clears scoreboard entries.

---
 rtl/cpu_types.sv | 29 ++
 rtl/reg_scoreboard.sv | 32 +++
 rtl/issue_queue.sv | 117 +++++++++++
 tb/tb_issue_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// Shared CPU types: opcodes and the decoded task record passed from decode to execute.
package cpu_types;

   typedef enum logic [3:0] {
      OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR,
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR
   } opcode_t;

   typedef struct packed {
      opcode_t     opcode;
      logic        rs1_used;
      logic [4:0]  rs1_addr;
      logic        rs2_used;
      logic [4:0]  rs2_addr;
      logic        rd_used;
      logic [4:0]  rd_addr;
      logic [31:0] op_a;
      logic [31:0] op_b;
   } task_t;

   function automatic logic is_mem(opcode_t op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic is_ctrl(opcode_t op);
      return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: two issue-time set ports, one writeback clear port.
module reg_scoreboard (
   input  logic        clk,
   input  logic        rst,
   input  logic        set0_valid,
   input  logic [4:0]  set0_addr,
   input  logic        set1_valid,
   input  logic [4:0]  set1_addr,
   input  logic        clr_valid,
   input  logic [4:0]  clr_addr,
   output logic [31:0] busy
);

   logic [31:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      // Clear first so a same-cycle set of the same register wins.
      if (clr_valid) busy_d[clr_addr] = 1'b0;
      if (set0_valid) busy_d[set0_addr] = 1'b1;
      if (set1_valid) busy_d[set1_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/issue_queue.sv
// Dual-enqueue, dual-issue in-order issue queue with scoreboard-gated, registered issue slots.
module issue_queue
   import cpu_types::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     FLUSH,
   input  logic                     IN_VALID_0,
   input  logic                     IN_VALID_1,
   input  task_t                    TASK_IN_0,
   input  task_t                    TASK_IN_1,
   output logic                     IN_READY,
   output logic                     ISSUE_VALID_0,
   output logic                     ISSUE_VALID_1,
   output task_t                    ISSUE_TASK_0,
   output task_t                    ISSUE_TASK_1,
   input  logic                     ISSUE_READY,
   input  logic                     WB_VALID,
   input  logic [4:0]               WB_RD,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   task_t         mem [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic          iv0_q, iv1_q;
   task_t         it0_q, it1_q;
   logic [31:0]   busy;

   task_t      h0, h1;
   logic       in_ready, advance, iss0, iss1, hazard, enq0, enq1;
   logic [1:0] enq_n, deq_n;

   function automatic logic is_clear(task_t t, logic [31:0] b);
      return (!t.rs1_used || !b[t.rs1_addr]) &&
             (!t.rs2_used || !b[t.rs2_addr]) &&
             (!t.rd_used  || !b[t.rd_addr]);
   endfunction

   assign in_ready = !RST && ((CW'(DEPTH) - count_q) >= CW'(2));
   assign h0 = mem[head_q];
   assign h1 = mem[head_q + PW'(1)];

   always_comb begin
      advance = (!iv0_q && !iv1_q) || ISSUE_READY;
      // Head's destination is not busy yet, so a younger reader/writer must be held back.
      hazard  = h0.rd_used && (h0.rd_addr != 5'd0) &&
                ((h1.rs1_used && (h1.rs1_addr == h0.rd_addr)) ||
                 (h1.rs2_used && (h1.rs2_addr == h0.rd_addr)) ||
                 (h1.rd_used  && (h1.rd_addr  == h0.rd_addr)));
      iss0    = advance && !FLUSH && (count_q != '0) && is_clear(h0, busy);
      iss1    = iss0 && (count_q >= CW'(2)) && is_clear(h1, busy) && !hazard &&
                !(is_mem(h0.opcode) && is_mem(h1.opcode)) && !is_ctrl(h0.opcode);
      enq0    = in_ready && IN_VALID_0 && !FLUSH;
      enq1    = enq0 && IN_VALID_1;
      enq_n   = {1'b0, enq0} + {1'b0, enq1};
      deq_n   = {1'b0, iss0} + {1'b0, iss1};
   end

   always_ff @(posedge CLK) begin
      if (enq0) mem[tail_q] <= TASK_IN_0;
      if (enq1) mem[tail_q + PW'(1)] <= TASK_IN_1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         iv0_q   <= 1'b0;
         iv1_q   <= 1'b0;
         it0_q   <= '0;
         it1_q   <= '0;
      end else if (FLUSH) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         iv0_q   <= 1'b0;
         iv1_q   <= 1'b0;
      end else begin
         head_q  <= head_q + PW'(deq_n);
         tail_q  <= tail_q + PW'(enq_n);
         count_q <= count_q + CW'(enq_n) - CW'(deq_n);
         if (advance) begin
            iv0_q <= iss0;
            iv1_q <= iss1;
            it0_q <= iss0 ? h0 : '0;
            it1_q <= iss1 ? h1 : '0;
         end
      end
   end

   reg_scoreboard u_scoreboard (
      .clk        (CLK),
      .rst        (RST),
      .set0_valid (iss0 && h0.rd_used),
      .set0_addr  (h0.rd_addr),
      .set1_valid (iss1 && h1.rd_used),
      .set1_addr  (h1.rd_addr),
      .clr_valid  (WB_VALID),
      .clr_addr   (WB_RD),
      .busy       (busy)
   );

   assign IN_READY      = in_ready;
   assign ISSUE_VALID_0 = iv0_q;
   assign ISSUE_VALID_1 = iv1_q;
   assign ISSUE_TASK_0  = it0_q;
   assign ISSUE_TASK_1  = it1_q;
   assign COUNT         = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed and randomized bench for issue_queue against a queue-based reference model.
module tb_issue_queue;
   import cpu_types::*;

   localparam int DEPTH = 8;

   logic        CLK, RST, FLUSH, IN_VALID_0, IN_VALID_1, ISSUE_READY, WB_VALID;
   logic [4:0]  WB_RD;
   task_t       TASK_IN_0, TASK_IN_1, ISSUE_TASK_0, ISSUE_TASK_1;
   logic        IN_READY, ISSUE_VALID_0, ISSUE_VALID_1;
   logic [3:0]  COUNT;

   issue_queue #(.DEPTH(DEPTH)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .FLUSH         (FLUSH),
      .IN_VALID_0    (IN_VALID_0),
      .IN_VALID_1    (IN_VALID_1),
      .TASK_IN_0     (TASK_IN_0),
      .TASK_IN_1     (TASK_IN_1),
      .IN_READY      (IN_READY),
      .ISSUE_VALID_0 (ISSUE_VALID_0),
      .ISSUE_VALID_1 (ISSUE_VALID_1),
      .ISSUE_TASK_0  (ISSUE_TASK_0),
      .ISSUE_TASK_1  (ISSUE_TASK_1),
      .ISSUE_READY   (ISSUE_READY),
      .WB_VALID      (WB_VALID),
      .WB_RD         (WB_RD),
      .COUNT         (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: program-order queue, busy set, issue slots.
   task_t       mq[$];
   logic [31:0] m_busy = '0;
   logic        m_v0 = 1'b0, m_v1 = 1'b0;
   task_t       m_t0 = '0, m_t1 = '0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_clear(task_t t);
      if (t.rs1_used && m_busy[t.rs1_addr]) return 0;
      if (t.rs2_used && m_busy[t.rs2_addr]) return 0;
      if (t.rd_used && m_busy[t.rd_addr]) return 0;
      return 1;
   endfunction

   function automatic bit m_can_pair(task_t a, task_t b);
      if (a.rd_used && a.rd_addr != 0) begin
         if (b.rs1_used && b.rs1_addr == a.rd_addr) return 0;
         if (b.rs2_used && b.rs2_addr == a.rd_addr) return 0;
         if (b.rd_used && b.rd_addr == a.rd_addr) return 0;
      end
      if ((a.opcode == OP_LOAD || a.opcode == OP_STORE) &&
          (b.opcode == OP_LOAD || b.opcode == OP_STORE)) return 0;
      if (a.opcode == OP_BRANCH || a.opcode == OP_JAL || a.opcode == OP_JALR) return 0;
      return 1;
   endfunction

   task automatic model_step();
      bit          rdy, adv;
      int          n;
      logic [31:0] nb;
      rdy = !RST && (DEPTH - mq.size()) >= 2;
      if (RST) begin
         mq.delete();
         m_busy = '0;
         m_v0 = 0; m_v1 = 0; m_t0 = '0; m_t1 = '0;
         return;
      end
      adv = (!m_v0 && !m_v1) || ISSUE_READY;
      n = 0;
      if (adv && !FLUSH && mq.size() >= 1 && m_clear(mq[0])) begin
         n = 1;
         if (mq.size() >= 2 && m_clear(mq[1]) && m_can_pair(mq[0], mq[1])) n = 2;
      end
      nb = m_busy;
      if (WB_VALID) nb[WB_RD] = 1'b0;
      if (n >= 1 && mq[0].rd_used) nb[mq[0].rd_addr] = 1'b1;
      if (n == 2 && mq[1].rd_used) nb[mq[1].rd_addr] = 1'b1;
      nb[0] = 1'b0;
      if (FLUSH) begin
         mq.delete();
         m_v0 = 0; m_v1 = 0;
      end else begin
         if (adv) begin
            m_v0 = (n >= 1);
            m_v1 = (n == 2);
            if (n >= 1) m_t0 = mq[0];
            if (n == 2) m_t1 = mq[1];
         end
         for (int k = 0; k < n; k++) void'(mq.pop_front());
         if (rdy && IN_VALID_0) begin
            mq.push_back(TASK_IN_0);
            if (IN_VALID_1) mq.push_back(TASK_IN_1);
         end
      end
      m_busy = nb;
   endtask

   task automatic compare_all();
      chk("valid0", ISSUE_VALID_0, m_v0);
      chk("valid1", ISSUE_VALID_1, m_v1);
      if (m_v0) chk("task0", ISSUE_TASK_0, m_t0);
      if (m_v1) chk("task1", ISSUE_TASK_1, m_t1);
      chk("count", COUNT, mq.size());
      chk("in_ready", IN_READY, !RST && (DEPTH - mq.size()) >= 2);
      chk("busy", dut.busy, m_busy);
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
      compare_all();
   endtask

   task automatic idle();
      IN_VALID_0 = 0; IN_VALID_1 = 0; WB_VALID = 0; FLUSH = 0; RST = 0;
   endtask

   function automatic task_t mk(opcode_t op, logic rdu, logic [4:0] rd,
                                logic r1u, logic [4:0] r1, logic r2u, logic [4:0] r2);
      task_t t;
      t.opcode = op;
      t.rd_used = rdu;   t.rd_addr = rd;
      t.rs1_used = r1u;  t.rs1_addr = r1;
      t.rs2_used = r2u;  t.rs2_addr = r2;
      t.op_a = $urandom;
      t.op_b = $urandom;
      return t;
   endfunction

   function automatic task_t rnd_task();
      return mk(opcode_t'(4'($urandom_range(0, 9))), 1'($urandom), 5'($urandom_range(0, 7)),
                1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
   endfunction

   task automatic wb(input logic [4:0] r);
      idle(); WB_VALID = 1; WB_RD = r; tick(); idle();
   endtask

   initial begin
      int rd;
      TASK_IN_0 = '0; TASK_IN_1 = '0; WB_RD = '0; ISSUE_READY = 0;
      idle();
      RST = 1;
      tick();
      tick();
      chk("rst_task0", ISSUE_TASK_0, 0);
      chk("rst_count", COUNT, 0);
      RST = 0;
      #1;
      chk("ready_after_rst", IN_READY, 1);

      // Independent pair.
      ISSUE_READY = 1;
      IN_VALID_0 = 1; IN_VALID_1 = 1;
      TASK_IN_0 = mk(OP_ADDI, 1, 1, 1, 0, 0, 0);
      TASK_IN_1 = mk(OP_ADDI, 1, 2, 1, 0, 0, 0);
      tick();
      idle();
      tick();
      chk("pair_v0", ISSUE_VALID_0, 1);
      chk("pair_v1", ISSUE_VALID_1, 1);
      chk("pair_busy1", dut.busy[1], 1);
      chk("pair_busy2", dut.busy[2], 1);
      chk("pair_count", COUNT, 0);
      wb(1);
      wb(2);

      // Dependent pair: ADD waits for x3 writeback.
      IN_VALID_0 = 1; IN_VALID_1 = 1;
      TASK_IN_0 = mk(OP_ADDI, 1, 3, 1, 0, 0, 0);
      TASK_IN_1 = mk(OP_ADD, 1, 4, 1, 3, 1, 5);
      tick();
      idle();
      tick();
      chk("dep_v1", ISSUE_VALID_1, 0);
      tick();
      chk("dep_hold", ISSUE_VALID_0, 0);
      wb(3);
      tick();
      chk("dep_issue", ISSUE_VALID_0, 1);
      chk("dep_rd", ISSUE_TASK_0.rd_addr, 4);
      wb(4);

      // Fill with execute stalled; pointers wrap.
      ISSUE_READY = 0;
      rd = 8;
      for (int i = 0; i < 8 && mq.size() < 6; i++) begin
         IN_VALID_0 = 1; IN_VALID_1 = 1;
         TASK_IN_0 = mk(OP_ADDI, 1, 5'(rd), 0, 0, 0, 0);
         TASK_IN_1 = mk(OP_ADDI, 1, 5'(rd + 1), 0, 0, 0, 0);
         rd += 2;
         tick();
      end
      IN_VALID_0 = 1; IN_VALID_1 = 0;
      TASK_IN_0 = mk(OP_ADDI, 1, 5'(rd), 0, 0, 0, 0);
      tick();
      chk("full_ready", IN_READY, 0);
      chk("full_count", COUNT, 7);
      IN_VALID_0 = 1; IN_VALID_1 = 1;
      TASK_IN_0 = mk(OP_ADDI, 1, 30, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("hold_rd", ISSUE_TASK_0.rd_addr, 8);
      idle();
      ISSUE_READY = 1;
      tick();
      chk("drain_rd", ISSUE_TASK_0.rd_addr, 10);
      for (int i = 0; i < 5; i++) tick();
      chk("drain_count", COUNT, 0);
      for (int r = 8; r <= 16; r++) wb(5'(r));

      // Control-flow head issues alone; memory pair serialises.
      IN_VALID_0 = 1; IN_VALID_1 = 1;
      TASK_IN_0 = mk(OP_BRANCH, 0, 0, 1, 0, 1, 0);
      TASK_IN_1 = mk(OP_ADDI, 1, 20, 1, 0, 0, 0);
      tick();
      idle();
      tick();
      chk("br_v0", ISSUE_VALID_0, 1);
      chk("br_v1", ISSUE_VALID_1, 0);
      tick();
      chk("br_next", ISSUE_TASK_0.rd_addr, 20);
      IN_VALID_0 = 1; IN_VALID_1 = 1;
      TASK_IN_0 = mk(OP_LOAD, 1, 21, 1, 0, 0, 0);
      TASK_IN_1 = mk(OP_STORE, 0, 0, 1, 0, 1, 0);
      tick();
      idle();
      tick();
      chk("ls_v1", ISSUE_VALID_1, 0);
      tick();
      chk("ls_next", ISSUE_TASK_0.opcode, OP_STORE);
      wb(20);
      wb(21);
      tick();

      // Flush with five queued; issued destinations stay busy.
      ISSUE_READY = 0;
      for (int i = 0; i < 3; i++) begin
         IN_VALID_0 = 1; IN_VALID_1 = 1;
         TASK_IN_0 = mk(OP_ADDI, 1, 5'(24 + 2 * i), 0, 0, 0, 0);
         TASK_IN_1 = mk(OP_ADDI, 1, 5'(25 + 2 * i), 0, 0, 0, 0);
         tick();
      end
      IN_VALID_1 = 0;
      TASK_IN_0 = mk(OP_ADDI, 1, 30, 0, 0, 0, 0);
      tick();
      chk("pre_flush_count", COUNT, 5);
      FLUSH = 1;
      TASK_IN_0 = mk(OP_ADDI, 1, 31, 0, 0, 0, 0);
      tick();
      chk("flush_count", COUNT, 0);
      chk("flush_v0", ISSUE_VALID_0, 0);
      chk("flush_busy24", dut.busy[24], 1);
      idle();
      wb(24);
      wb(25);

      // Set wins over same-cycle writeback.
      ISSUE_READY = 1;
      IN_VALID_0 = 1;
      TASK_IN_0 = mk(OP_ADDI, 1, 7, 1, 0, 0, 0);
      tick();
      idle();
      WB_VALID = 1; WB_RD = 7;
      tick();
      chk("set_wins", dut.busy[7], 1);
      idle();

      // Reset and flush together: scoreboard cleared.
      RST = 1; FLUSH = 1;
      tick();
      chk("rst_flush_busy", dut.busy, 0);
      idle();
      tick();

      // Randomized phase.
      for (int c = 0; c < 3000; c++) begin
         RST = ($urandom_range(0, 299) == 0);
         FLUSH = ($urandom_range(0, 49) == 0);
         IN_VALID_0 = 1'($urandom);
         IN_VALID_1 = 1'($urandom);
         TASK_IN_0 = rnd_task();
         TASK_IN_1 = rnd_task();
         ISSUE_READY = ($urandom_range(0, 3) != 0);
         WB_VALID = 1'($urandom);
         WB_RD = 5'($urandom_range(0, 7));
         tick();
      end
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
